// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and default sizes shared by the serial pattern transmitter and detector.
package serial_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 9;
    localparam int DEF_LEN_W = 4;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-in/serial-out register, MSB-first.
module piso_shift #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);
    logic [WIDTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= d;
        else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
    end
    assign msb = sr[WIDTH-1];
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: framed MSB-first serial transmitter with start/busy/done handshake.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);
    state_t           state, state_n;
    logic [LEN_W-1:0] count, count_n, eff_len, shamt;
    logic [WIDTH-1:0] aligned;
    logic             accept, load, shift, msb;
    logic             out_n, valid_n, busy_n, done_n;
    // The first bit goes straight to the output register, so the shifter holds the remainder.
    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .d     ({aligned[WIDTH-2:0], 1'b0}),
        .msb   (msb)
    );
    always_comb begin
        eff_len = (len > WMAX) ? WMAX : len;
        shamt   = WMAX - eff_len;
        aligned = pattern << shamt;
        accept  = start && (state != SHIFT);
        load    = accept && (eff_len != '0);
        shift   = (state == SHIFT) && (count != LEN_W'(1));
        state_n = state;
        count_n = count;
        out_n   = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        if (load) begin
            state_n = SHIFT;
            count_n = eff_len;
            out_n   = aligned[WIDTH-1];
            valid_n = 1'b1;
            busy_n  = 1'b1;
        end else if (accept) begin
            state_n = DONE;
            done_n  = 1'b1;
        end else if (state == SHIFT) begin
            if (count == LEN_W'(1)) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                count_n = count - LEN_W'(1);
                out_n   = msb;
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            out       <= out_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: vector table plus scoreboard and hand-written corner sequences.
module tb_serial_pattern_tx;
    import serial_pkg::*;
    typedef struct {
        logic [8:0] p;
        logic [3:0] l;
        logic [8:0] exp;
        int         n;
    } vec_t;
    typedef struct {
        bit   is_done;
        logic b;
    } sb_t;
    logic       clk = 1'b0;
    logic       rst, start, out, out_valid, busy, done;
    logic [8:0] pattern;
    logic [3:0] len;
    int         errors = 0;
    int         checks = 0;
    sb_t        exp_q[$];
    sb_t        e_m;
    logic [3:0] det_sr = '0;
    int         det_hits = 0;
    vec_t       tv[7];
    serial_pattern_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask
    // Scoreboard and a 1101 detector watching the raw line every cycle.
    always @(negedge clk) begin
        if (out_valid || done) begin
            if (exp_q.size() == 0) chk("sb_extra", 32'(out_valid), 32'(done));
            else begin
                e_m = exp_q.pop_front();
                chk("sb_kind", 32'(done), 32'(e_m.is_done));
                if (!e_m.is_done) chk("sb_bit", 32'(out), 32'(e_m.b));
            end
        end
        det_sr = {det_sr[2:0], out};
        if (det_sr == 4'b1101) det_hits++;
    end
    task automatic kick(input logic [8:0] p, input logic [3:0] l, input logic [8:0] exp, input int n);
        pattern = p;
        len     = l;
        start   = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back('{1'b0, exp[8-k]});
        exp_q.push_back('{1'b1, 1'b0});
        @(negedge clk);
        start   = 1'b0;
        pattern = ~p;
        len     = 4'($urandom);
    endtask
    task automatic expect_frame(input logic [8:0] exp, input int n, input int poke);
        for (int k = 0; k < n; k++) begin
            chk("valid", 32'(out_valid), 1);
            chk("bit", 32'(out), 32'(exp[8-k]));
            chk("busy", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            start   = (k == poke);
            pattern = 9'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done", 32'(done), 1);
        chk("done_valid", 32'(out_valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_out", 32'(out), 0);
    endtask
    task automatic expect_idle(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_out"}, 32'(out), 0);
    endtask
    initial begin
        tv[0] = '{9'b000001101, 4'd4,  9'b110100000, 4};
        tv[1] = '{9'b100011101, 4'd9,  9'b100011101, 9};
        tv[2] = '{9'h1FF,       4'd15, 9'b111111111, 9};
        tv[3] = '{9'h1AB,       4'd0,  9'b000000000, 0};
        tv[4] = '{9'b111110010, 4'd3,  9'b010000000, 3};
        tv[5] = '{9'h155,       4'd1,  9'b100000000, 1};
        tv[6] = '{9'b010101010, 4'd10, 9'b010101010, 9};
        rst = 1'b1; start = 1'b0; pattern = '0; len = '0;
        repeat (3) @(negedge clk);
        expect_idle("reset");
        start = 1'b1;
        @(negedge clk);
        expect_idle("reset_start");
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            kick(tv[i].p, tv[i].l, tv[i].exp, tv[i].n);
            expect_frame(tv[i].exp, tv[i].n, -1);
            @(negedge clk);
            expect_idle("tbl_idle");
        end
        // Back-to-back: second start held in the DONE cycle.
        det_sr = '0;
        det_hits = 0;
        kick(9'b000001101, 4'd4, 9'b110100000, 4);
        expect_frame(9'b110100000, 4, -1);
        kick(9'b000000101, 4'd3, 9'b101000000, 3);
        expect_frame(9'b101000000, 3, -1);
        @(negedge clk);
        expect_idle("b2b_idle");
        chk("det_hits", 32'(det_hits), 1);
        // start pulsed mid-frame must be ignored.
        kick(9'b100011101, 4'd9, 9'b100011101, 9);
        expect_frame(9'b100011101, 9, 3);
        @(negedge clk);
        expect_idle("poke_idle");
        // Reset after the second bit of a 9-bit frame.
        kick(9'b100011101, 4'd9, 9'b100011101, 9);
        chk("pre_rst_bit0", 32'(out), 1);
        @(negedge clk);
        chk("pre_rst_bit1", 32'(out), 0);
        rst = 1'b1;
        @(negedge clk);
        expect_idle("rst_mid");
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        expect_idle("rst_after");
        kick(9'b000001101, 4'd4, 9'b110100000, 4);
        expect_frame(9'b110100000, 4, -1);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmitter for the serial bit-sequence detector: loads a parallel pattern and emits it one bit per clock on `out`, MSB-first.
- Produces the stimulus streams the detector consumes, e.g. 1101 and 100011101, with explicit framing.
- Sits upstream of the detector's `in` port.
- Start/busy/done handshake lets a controller or bench chain frames back-to-back.

Parameters:
- WIDTH, 9, maximum pattern length in bits.
- LEN_W, 4, width of the length field; must satisfy 2^LEN_W > WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to transmit; sampled only in IDLE or DONE.
- pattern  input  WIDTH  bits to send; the frame is pattern[len-1:0], sent pattern[len-1] first.
- len  input  LEN_W  number of bits to send.
- out  output  1  serial data bit; 0 whenever out_valid=0.
- out_valid  output  1  high while `out` carries a frame bit.
- busy  output  1  high while a frame is being shifted.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, out=0, out_valid=0, busy=0, done=0; the shift register and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 with len>=1: latch pattern, load count=effective length, go to SHIFT.
  - start=1 with len=0: go directly to DONE; no bits are emitted.
  - start=0: stay in IDLE.
- SHIFT:
  - Each cycle, out = current MSB of the frame and out_valid=1, busy=1; then shift left and decrement count.
  - When the last bit is presented (count=1 on that cycle), next state is DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, out_valid=0, out=0.
  - start=1 in DONE is accepted with the same rules as IDLE, giving zero-gap back-to-back frames apart from the DONE cycle.
  - Otherwise return to IDLE.
- Latency: start sampled at edge T gives the first bit valid in cycle T+1. The last bit is valid in T+len, and done is high in T+len+1.
- Length rules:
  - len>WIDTH is clamped to WIDTH; the frame is then pattern[WIDTH-1:0].
  - Bits of pattern at or above the effective length are ignored.
- start while in SHIFT is ignored; no queuing.
- pattern and len changes after the start cycle have no effect on the frame in flight.
- rst asserted mid-frame: the next edge returns to IDLE with all outputs 0. There is no done pulse and no partial bit after reset.
- rst has priority over start on the same edge.
- The counter uses LEN_W bits and never wraps; it is only loaded when nonzero and decremented to 1.

Decomposition:
- Shared package `serial_pkg`:
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH/LEN_W values.
  - Shared by the detector and this transmitter.
- One natural sub-module: `piso_shift`, a WIDTH-bit parallel-in/serial-out register.
  - Ports: clk, rst, load, shift, d[WIDTH-1:0], msb.
  - The top module handles alignment by pre-shifting the loaded word left by WIDTH-len so the frame's first bit lands in the MSB.
- The top holds the FSM, counter, clamp logic and output registers.

Test Plan:
- Reset, then start with pattern=9'b000001101, len=4 → out_valid high for 4 cycles with out=1,1,0,1; done pulse on the 5th cycle; busy high exactly 4 cycles.
- Start with pattern=9'b100011101, len=9 → out = 1,0,0,0,1,1,1,0,1 over 9 cycles, then done=1 for one cycle, then IDLE with out=0.
- Back-to-back frames:
  - First frame 1101 (len=4), then start held high in the DONE cycle with pattern=9'b000000101, len=3.
  - Required: bits 1,1,0,1, a one-cycle gap with done=1, then 1,0,1 and a second done pulse.
  - A detector wired to `out` must flag 1101 exactly once.
- Edge lengths:
  - len=0 → no out_valid cycles; done=1 in cycle T+1.
  - len=15 with pattern=9'h1FF → exactly 9 ones (clamped), then done.
- Mid-frame disturbances:
  - start pulsed during SHIFT, and pattern changed mid-frame → frame unchanged.
  - rst asserted after the 2nd bit of a len=9 frame → next cycle out=0, out_valid=0, busy=0, done=0 and the FSM is in IDLE.
  - A new start after rst deasserts sends a complete fresh frame.
